// File: rtl/ts_tx_player_pkg.sv
// Shared TS link definitions: idle/comma word, controller states and the
// {k,d} word layout used by both the transmit player and the receive spy.
package ts_tx_player_pkg;

    localparam logic [15:0] TS_IDLE_D = 16'h50BC;
    localparam logic [1:0]  TS_IDLE_K = 2'b01;

    localparam int D_LSB  = 0;
    localparam int D_W    = 16;
    localparam int K_LSB  = 16;
    localparam int K_W    = 2;
    localparam int WORD_W = K_W + D_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_TAIL = 2'd2
    } state_t;

    function automatic logic [WORD_W-1:0] pack_word(input logic [K_W-1:0] k,
                                                     input logic [D_W-1:0] d);
        return {k, d};
    endfunction

endpackage

// File: rtl/ts_tx_ram.sv
// Pattern buffer: one write port, two registered read ports, read-before-write.
// Port B loads FILL instead of memory when not enabled so it can drive tx directly.
module ts_tx_ram #(
    parameter int           AW   = 6,
    parameter int           W    = 18,
    parameter logic [W-1:0] FILL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] a_addr,
    output logic [W-1:0]  a_data,
    input  logic [AW-1:0] b_addr,
    input  logic          b_en,
    output logic [W-1:0]  b_data
);

    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_data <= '0;
            b_data <= FILL;
        end else begin
            a_data <= mem[a_addr];
            b_data <= b_en ? mem[b_addr] : FILL;
        end
    end

endmodule

// File: rtl/ts_tx_player.sv
// TS link pattern player: plays a software-loaded buffer once or in a loop,
// emitting the idle/comma word at all other times.
//
//   state   | meaning
//   --------+----------------------------------------------------
//   IDLE    | idle word on tx, waiting for start
//   PLAY    | buffer[rptr] loaded onto tx every edge
//   TAIL    | one-shot finished: back to idle word, pulse done
module ts_tx_player
    import ts_tx_player_pkg::*;
#(
    parameter int          AW     = 6,
    parameter logic [15:0] IDLE_D = TS_IDLE_D,
    parameter logic [1:0]  IDLE_K = TS_IDLE_K
) (
    input  logic              tx_clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic [AW-1:0]     last_addr,
    output logic [D_W-1:0]    tx_d,
    output logic [K_W-1:0]    tx_k,
    output logic              busy,
    output logic              done
);

    localparam logic [WORD_W-1:0] IDLE_WORD = pack_word(IDLE_K, IDLE_D);

    state_t            state;
    logic [AW-1:0]     rptr;
    logic [AW-1:0]     last_q;
    logic              loop_q;
    logic              play_rd;
    logic [WORD_W-1:0] tx_word;

    // The RAM's play port register is the tx register; it loads the idle
    // word on any edge where PLAY is not emitting a buffer entry.
    assign play_rd = (state == ST_PLAY) && !stop;

    ts_tx_ram #(
        .AW   (AW),
        .W    (WORD_W),
        .FILL (IDLE_WORD)
    ) u_ram (
        .clk    (tx_clk),
        .rst_n  (rst_n),
        .we     (wr_en),
        .waddr  (wr_addr),
        .wdata  (wr_data),
        .a_addr (rd_addr),
        .a_data (rd_data),
        .b_addr (rptr),
        .b_en   (play_rd),
        .b_data (tx_word)
    );

    assign tx_d = tx_word[D_LSB +: D_W];
    assign tx_k = tx_word[K_LSB +: K_W];

    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            rptr   <= '0;
            last_q <= '0;
            loop_q <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        last_q <= last_addr;
                        loop_q <= loop;
                        rptr   <= '0;
                        busy   <= 1'b1;
                        state  <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (rptr == last_q) begin
                        if (loop_q) rptr <= '0;
                        else        state <= ST_TAIL;
                    end else begin
                        rptr <= rptr + 1'b1;
                    end
                end
                ST_TAIL: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ts_tx_player.sv
// Scoreboard bench for ts_tx_player: a cycle-level reference model pushes the
// expected outputs for every edge; a monitor pops and compares on the falling edge.
module tb_ts_tx_player;

    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          tx_clk = 1'b0;
    logic          rst_n  = 1'b0;
    logic          wr_en  = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [17:0]   wr_data = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [17:0]   rd_data;
    logic          start = 1'b0;
    logic          stop  = 1'b0;
    logic          loop  = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [15:0]   tx_d;
    logic [1:0]    tx_k;
    logic          busy;
    logic          done;

    always #5 tx_clk = ~tx_clk;

    ts_tx_player #(.AW(AW)) dut (
        .tx_clk    (tx_clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .start     (start),
        .stop      (stop),
        .loop      (loop),
        .last_addr (last_addr),
        .tx_d      (tx_d),
        .tx_k      (tx_k),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [17:0] tx;
        logic        busy;
        logic        done;
        logic        rd_chk;
        logic [17:0] rd;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: playback tracked as elapsed cycles since start,
    // word index = elapsed count (mod length when looping).
    logic [17:0] mdl_mem   [DEPTH];
    bit          mdl_known [DEPTH];
    bit          m_play = 0;
    bit          m_tail = 0;
    int          m_start = 0;
    int          m_last  = 0;
    bit          m_loop  = 0;

    always @(posedge tx_clk) begin
        exp_t e;
        int   idx;
        cyc++;
        e.tx     = {2'b01, 16'h50BC};
        e.busy   = 1'b0;
        e.done   = 1'b0;
        e.rd_chk = 1'b0;
        e.rd     = '0;
        if (!rst_n) begin
            m_play   = 0;
            m_tail   = 0;
            e.rd_chk = 1'b1;
        end else begin
            e.rd_chk = mdl_known[rd_addr];
            e.rd     = mdl_mem[rd_addr];
            if (m_tail) begin
                e.done = 1'b1;
                m_tail = 0;
            end else if (m_play) begin
                idx = cyc - m_start - 1;
                if (stop) begin
                    m_play = 0;
                end else begin
                    if (m_loop) idx = idx % (m_last + 1);
                    e.tx   = mdl_mem[idx];
                    e.busy = 1'b1;
                    if (!m_loop && idx == m_last) begin
                        m_play = 0;
                        m_tail = 1;
                    end
                end
            end else if (start && !stop) begin
                m_play  = 1;
                m_start = cyc;
                m_last  = int'(last_addr);
                m_loop  = loop;
                e.busy  = 1'b1;
            end
            if (wr_en) begin
                mdl_mem[wr_addr]   = wr_data;
                mdl_known[wr_addr] = 1;
            end
        end
        sbq.push_back(e);
    end

    always @(negedge tx_clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("tx_d", 32'(tx_d), 32'(e.tx[15:0]));
            check("tx_k", 32'(tx_k), 32'(e.tx[17:16]));
            check("busy", 32'(busy), 32'(e.busy));
            check("done", 32'(done), 32'(e.done));
            if (e.rd_chk) check("rd_data", 32'(rd_data), 32'(e.rd));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge tx_clk);
    endtask

    task automatic wr(input int a, input logic [17:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        tick(1);
        wr_en   = 1'b0;
    endtask

    task automatic do_start(input int last, input bit lp);
        start     = 1'b1;
        last_addr = AW'(last);
        loop      = lp;
        tick(1);
        start     = 1'b0;
        last_addr = AW'($urandom);
        loop      = 1'($urandom);
    endtask

    task automatic load_ramp;
        for (int i = 0; i < 4; i++) wr(i, {2'b00, 16'h1000 + 16'(i)});
    endtask

    initial begin
        int len;
        tick(3);
        rst_n = 1'b1;
        tick(100);

        // fill the whole buffer with random words, reading each address as it is written
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = AW'(i);
            wr(i, 18'($urandom));
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = AW'(DEPTH - 1 - i);
            tick(1);
        end

        load_ramp();
        do_start(3, 0);
        tick(8);

        do_start(1, 1);
        tick(4);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(4);

        do_start(0, 0);
        tick(4);

        for (int i = 0; i < DEPTH; i++) wr(i, 18'(i));
        do_start(63, 0);
        tick(70);

        // rewrite entry 2 on the edge it is played, with a redundant start
        load_ramp();
        do_start(3, 0);
        tick(2);
        wr_en   = 1'b1;
        wr_addr = 2;
        wr_data = {2'b00, 16'hBEEF};
        start   = 1'b1;
        tick(1);
        wr_en   = 1'b0;
        start   = 1'b0;
        tick(6);
        do_start(3, 0);
        tick(7);

        start = 1'b1;
        stop  = 1'b1;
        tick(1);
        start = 1'b0;
        stop  = 1'b0;
        tick(3);

        do_start(20, 0);
        tick(5);
        #2 rst_n = 1'b0;
        #1;
        check("rst_tx_d", 32'(tx_d), 32'h50BC);
        check("rst_tx_k", 32'(tx_k), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        tick(3);
        #2 rst_n = 1'b1;
        tick(1);
        do_start(3, 0);
        tick(7);

        for (int ep = 0; ep < 30; ep++) begin
            bit lp;
            lp  = 1'($urandom);
            len = ($urandom_range(0, 7) == 0) ? 63 : $urandom_range(0, 15);
            do_start(len, lp);
            for (int c = 0; c < (lp ? 24 : len + 6); c++) begin
                wr_en   = ($urandom_range(0, 3) == 0);
                wr_addr = AW'($urandom);
                wr_data = 18'($urandom);
                rd_addr = AW'($urandom);
                start   = ($urandom_range(0, 7) == 0);
                stop    = ($urandom_range(0, lp ? 15 : 39) == 0);
                tick(1);
            end
            wr_en = 1'b0;
            start = 1'b0;
            stop  = 1'b1;
            tick(1);
            stop  = 1'b0;
            tick(3);
        end

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
